// File: rtl/regulator_trim_calibrator.sv
// rtl/regulator_trim_calibrator.sv - SAR trim calibration controller for the on-chip regulator.
module regulator_trim_calibrator #(
  parameter int TRIM_WIDTH    = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cmp_high,
  input  logic                  manual_en,
  input  logic [TRIM_WIDTH-1:0] trim_manual,
  output logic [TRIM_WIDTH-1:0] trim,
  output logic                  busy,
  output logic                  done,
  output logic                  rail
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int BW = (TRIM_WIDTH > 2) ? $clog2(TRIM_WIDTH) : 1;
  localparam logic [CW-1:0]         CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0]         BIT_TOP  = BW'(TRIM_WIDTH - 1);
  localparam logic [TRIM_WIDTH-1:0] MID      = {1'b1, {(TRIM_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;

  state_t                  state, state_next;
  logic [TRIM_WIDTH-1:0]   code, code_next;
  logic [BW-1:0]           bit_idx, bit_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic [TRIM_WIDTH-1:0]   cal_q;
  logic                    cmp_meta, cmp_s;
  logic                    finish, finish_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= cmp_high;
      cmp_s    <= cmp_meta;
    end
  end

  always_comb begin
    state_next = state;
    code_next  = code;
    bit_next   = bit_idx;
    cnt_next   = cnt;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort && !busy) begin
          state_next = SETTLE;
          code_next  = MID;
          bit_next   = BIT_TOP;
          cnt_next   = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (abort)            state_next = IDLE;
        else if (cnt == '0)   state_next = DECIDE;
        else                  cnt_next   = cnt - 1'b1;
      end
      DECIDE: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          // comparator high means vout is above target: this bit overshoots
          if (cmp_s) code_next[bit_idx] = 1'b0;
          if (bit_idx != '0) begin
            code_next[bit_idx - 1'b1] = 1'b1;
            bit_next   = bit_idx - 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = SETTLE;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        finish     = !abort;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      code     <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      cal_q    <= '0;
      rail     <= 1'b0;
      busy     <= 1'b0;
      finish_q <= 1'b0;
      done     <= 1'b0;
      trim     <= '0;
    end else begin
      state    <= state_next;
      code     <= code_next;
      bit_idx  <= bit_next;
      cnt      <= cnt_next;
      busy     <= (state != IDLE) && !abort;
      finish_q <= finish;
      done     <= finish_q;
      if (finish) begin
        // offset-binary to two's complement is an MSB flip
        cal_q <= code ^ MID;
        rail  <= (code == '0) || (&code);
      end
      if (busy)           trim <= code ^ MID;
      else if (manual_en) trim <= trim_manual;
      else                trim <= cal_q;
    end
  end

endmodule

// File: tb/tb_regulator_trim_calibrator.sv
// tb/tb_regulator_trim_calibrator.sv - directed bench for regulator_trim_calibrator.
module tb_regulator_trim_calibrator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cmp_high;
  logic       manual_en = 1'b0;
  logic [3:0] trim_manual = 4'h0;
  logic [3:0] trim;
  logic       busy, done, rail;

  int checks = 0;
  int failures = 0;
  int target10 = 37;
  int done_at, busy_n, done_n;
  logic [3:0] trs [0:99];

  always #5 clk = ~clk;

  // vout*10 = 33 + 2*trim
  assign cmp_high = (33 + 2 * int'($signed(trim))) > target10;

  regulator_trim_calibrator #(.TRIM_WIDTH(4), .SETTLE_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cmp_high(cmp_high), .manual_en(manual_en), .trim_manual(trim_manual),
    .trim(trim), .busy(busy), .done(done), .rail(rail)
  );

  task automatic run_cal(input int tgt, input int restart_at, input int abort_at);
    target10 = tgt;
    done_at = -1;
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      abort = (k == abort_at);
      @(posedge clk);
      #1;
      trs[k] = trim;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = k;
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({trim, busy, done, rail} !== 7'b0) begin
      failures++;
      $display("FAIL reset_state actual=%b required=%b", {trim, busy, done, rail}, 7'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_nominal;
    logic [3:0] exp_seq [0:3];
    int idx [0:3];
    exp_seq[0] = 4'h0; exp_seq[1] = 4'h4; exp_seq[2] = 4'h2; exp_seq[3] = 4'h3;
    idx[0] = 2; idx[1] = 18; idx[2] = 35; idx[3] = 52;
    run_cal(37, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (trs[idx[i]] !== exp_seq[i]) begin
        failures++;
        $display("FAIL nominal_seq%0d actual=%h required=%h", i, trs[idx[i]], exp_seq[i]);
      end
    end
    checks++;
    if (done_at !== 70 || done_n !== 1) begin
      failures++;
      $display("FAIL nominal_done_latency actual=%0d count=%0d required=70 count=1", done_at, done_n);
    end
    checks++;
    if (busy_n !== 69) begin
      failures++;
      $display("FAIL nominal_busy_cycles actual=%0d required=69", busy_n);
    end
    checks++;
    if (trim !== 4'h2 || rail !== 1'b0) begin
      failures++;
      $display("FAIL nominal_result actual=%h/%b required=2/0", trim, rail);
    end
  endtask

  task automatic test_rail;
    run_cal(10, 0, 0);
    checks++;
    if (trim !== 4'h8 || rail !== 1'b1 || done_n !== 1) begin
      failures++;
      $display("FAIL rail_low actual=%h/%b/%0d required=8/1/1", trim, rail, done_n);
    end
    run_cal(50, 0, 0);
    checks++;
    if (trim !== 4'h7 || rail !== 1'b1 || done_n !== 1) begin
      failures++;
      $display("FAIL rail_high actual=%h/%b/%0d required=7/1/1", trim, rail, done_n);
    end
  endtask

  task automatic test_abort;
    run_cal(37, 0, 0);
    checks++;
    if (trim !== 4'h2) begin
      failures++;
      $display("FAIL abort_precal actual=%h required=2", trim);
    end
    run_cal(31, 0, 30);
    checks++;
    if (busy_n !== 29 || done_n !== 0) begin
      failures++;
      $display("FAIL abort_busy actual=%0d done=%0d required=29 done=0", busy_n, done_n);
    end
    checks++;
    if (trs[31] !== 4'h2 || trim !== 4'h2 || rail !== 1'b0) begin
      failures++;
      $display("FAIL abort_revert actual=%h/%h/%b required=2/2/0", trs[31], trim, rail);
    end
    run_cal(31, 0, 0);
    checks++;
    if (trim !== 4'hF || done_at !== 70 || rail !== 1'b0) begin
      failures++;
      $display("FAIL abort_rerun actual=%h/%0d/%b required=f/70/0", trim, done_at, rail);
    end
  endtask

  task automatic test_back_to_back;
    run_cal(37, 20, 0);
    checks++;
    if (done_at !== 70 || done_n !== 1 || busy_n !== 69) begin
      failures++;
      $display("FAIL restart_ignored actual=%0d/%0d/%0d required=70/1/69", done_at, done_n, busy_n);
    end
    checks++;
    if (trim !== 4'h2) begin
      failures++;
      $display("FAIL restart_result actual=%h required=2", trim);
    end
  endtask

  task automatic test_manual;
    @(negedge clk);
    manual_en = 1'b1;
    trim_manual = 4'hD;
    @(posedge clk);
    #1;
    checks++;
    if (trim !== 4'hD) begin
      failures++;
      $display("FAIL manual_select actual=%h required=d", trim);
    end
    @(negedge clk);
    manual_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (trim !== 4'h2) begin
      failures++;
      $display("FAIL manual_release actual=%h required=2", trim);
    end
  endtask

  task automatic test_async_reset;
    run_cal(50, 0, 0);
    target10 = 37;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || rail !== 1'b1) begin
      failures++;
      $display("FAIL async_pre actual=%b/%b required=1/1", busy, rail);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({trim, busy, done, rail} !== 7'b0) begin
      failures++;
      $display("FAIL async_reset actual=%b required=%b", {trim, busy, done, rail}, 7'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (trim !== 4'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_cal_lost actual=%h/%b required=0/0", trim, busy);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_rail;
    test_abort;
    test_back_to_back;
    test_manual;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
